// File: rtl/word_byte_serializer.sv
// ============================================================================
// Module   : word_byte_serializer
// Brief    : 16-bit word to tagged byte stream with one-word pending buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_byte_serializer #(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             WR,
  input  logic [15:0]      D,
  output logic             BUSY,
  output logic [7:0]       Q,
  output logic             STB,
  output logic             EN0,
  output logic             EN1,
  output logic             LD,
  input  logic             ACK,
  output logic             DONE,
  output logic             OVR,
  output logic [CNT_W-1:0] WCNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [15:0]      r_cur, w_cur_nxt;
  logic [15:0]      r_pend, w_pend_nxt;
  logic             r_pend_v, w_pend_v_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic             w_fire;
  logic             w_wr_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cur    <= 16'h0000;
      r_pend   <= 16'h0000;
      r_pend_v <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur    <= w_cur_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_v <= w_pend_v_nxt;
      r_done   <= w_done_nxt;
      r_ovr    <= w_ovr_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  assign w_fire  = (r_state != S_IDLE) && ACK;
  assign w_wr_ok = WR && !r_pend_v;

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_done_nxt   = 1'b0;
    w_wcnt_nxt   = r_wcnt;
    w_ovr_nxt    = r_ovr | (WR && r_pend_v);
    if (CLR) begin
      w_state_nxt  = S_IDLE;
      w_pend_v_nxt = 1'b0;
      w_ovr_nxt    = 1'b0;
      w_wcnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (WR) begin
            w_state_nxt = S_FIRST;
            w_cur_nxt   = D;
          end
        end
        S_FIRST: begin
          if (w_fire) w_state_nxt = S_SECOND;
          if (w_wr_ok) begin
            w_pend_nxt   = D;
            w_pend_v_nxt = 1'b1;
          end
        end
        S_SECOND: begin
          if (w_fire) begin
            w_done_nxt = 1'b1;
            w_wcnt_nxt = r_wcnt + CNT_W'(1);
            // Pending word takes priority; otherwise a concurrent write bypasses the buffer.
            if (r_pend_v) begin
              w_state_nxt  = S_FIRST;
              w_cur_nxt    = r_pend;
              w_pend_v_nxt = 1'b0;
            end else if (WR) begin
              w_state_nxt = S_FIRST;
              w_cur_nxt   = D;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (w_wr_ok) begin
            w_pend_nxt   = D;
            w_pend_v_nxt = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Byte lane outputs decode from state; IDLE keeps showing the last byte sent.
  always_comb begin
    STB = (r_state == S_FIRST) || (r_state == S_SECOND);
    LD  = (r_state == S_SECOND);
    EN0 = 1'b0;
    EN1 = 1'b0;
    if (r_state == S_FIRST) begin
      Q   = LOW_FIRST ? r_cur[7:0] : r_cur[15:8];
      EN0 = LOW_FIRST;
      EN1 = !LOW_FIRST;
    end else begin
      Q = LOW_FIRST ? r_cur[15:8] : r_cur[7:0];
      if (r_state == S_SECOND) begin
        EN0 = !LOW_FIRST;
        EN1 = LOW_FIRST;
      end
    end
  end

  assign BUSY = r_pend_v;
  assign DONE = r_done;
  assign OVR  = r_ovr;
  assign WCNT = r_wcnt;

endmodule

`default_nettype wire

// File: tb/tb_word_byte_serializer.sv
// ============================================================================
// Module   : tb_word_byte_serializer
// Brief    : Scoreboard bench for word_byte_serializer, both byte orders.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_word_byte_serializer;

  logic        CLK = 1'b0;
  logic        RESET, CLR, WR, ACK;
  logic [15:0] D;
  logic        BUSY, STB, EN0, EN1, LD, DONE, OVR;
  logic [7:0]  Q, WCNT;
  logic        h_busy, h_stb, h_en0, h_en1, h_ld, h_done, h_ovr;
  logic [7:0]  h_q;
  logic [1:0]  h_wcnt;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int exp_wcnt = 0;
  logic [10:0] q_lf[$];
  logic [10:0] q_hf[$];

  always #5 CLK = ~CLK;

  word_byte_serializer #(.LOW_FIRST(1'b1), .CNT_W(8)) u_dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .WR(WR), .D(D), .BUSY(BUSY), .Q(Q),
    .STB(STB), .EN0(EN0), .EN1(EN1), .LD(LD), .ACK(ACK), .DONE(DONE),
    .OVR(OVR), .WCNT(WCNT)
  );

  word_byte_serializer #(.LOW_FIRST(1'b0), .CNT_W(2)) u_dut_hf (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .WR(WR), .D(D), .BUSY(h_busy), .Q(h_q),
    .STB(h_stb), .EN0(h_en0), .EN1(h_en1), .LD(h_ld), .ACK(ACK), .DONE(h_done),
    .OVR(h_ovr), .WCNT(h_wcnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    q_lf.push_back({w[7:0], 3'b100});
    q_lf.push_back({w[15:8], 3'b011});
    q_hf.push_back({w[15:8], 3'b010});
    q_hf.push_back({w[7:0], 3'b101});
  endtask

  task automatic drain(input int n);
    ACK = 1'b1;
    repeat (n) tick();
    ACK = 1'b0;
  endtask

  task automatic flush();
    q_lf.delete();
    q_hf.delete();
  endtask

  // A byte seen with STB&&ACK here is consumed on the coming rising edge.
  always @(negedge CLK) begin
    if (!RESET && !CLR) begin
      if (DONE) n_done++;
      if (STB && ACK) begin
        if (q_lf.size() == 0) check("lf_unexpected_byte", {21'd0, Q, EN0, EN1, LD}, 32'hffff_ffff);
        else check("lf_byte", {21'd0, Q, EN0, EN1, LD}, {21'd0, q_lf.pop_front()});
      end
      if (h_stb && ACK) begin
        if (q_hf.size() == 0) check("hf_unexpected_byte", {21'd0, h_q, h_en0, h_en1, h_ld}, 32'hffff_ffff);
        else check("hf_byte", {21'd0, h_q, h_en0, h_en1, h_ld}, {21'd0, q_hf.pop_front()});
      end
    end
  end

  initial begin
    RESET = 1'b1; CLR = 1'b0; WR = 1'b0; ACK = 1'b0; D = 16'h0000;
    repeat (2) tick();
    check("rst_q", {24'd0, Q}, 32'h00);
    check("rst_flags", {STB, EN0, EN1, LD, BUSY, DONE, OVR}, 7'b0);
    check("rst_wcnt", {24'd0, WCNT}, 32'd0);
    RESET = 1'b0;
    tick();

    // basic word, ACK held
    push(16'h5aa5);
    D = 16'h5aa5; WR = 1'b1; ACK = 1'b1;
    tick();
    WR = 1'b0;
    check("t1_latency", {STB, EN0, LD, Q}, {3'b110, 8'ha5});
    repeat (3) tick();
    ACK = 1'b0;
    exp_wcnt++;
    check("t1_done", n_done, 1);
    check("t1_wcnt", {24'd0, WCNT}, exp_wcnt);
    check("t1_idle_stb", {31'd0, STB}, 0);

    // high-first instance on 1234
    push(16'h1234);
    D = 16'h1234; WR = 1'b1;
    tick();
    WR = 1'b0;
    check("t2_hf_first", {h_stb, h_en0, h_en1, h_ld, h_q}, {4'b1010, 8'h12});
    drain(3);
    exp_wcnt++;

    // held without ACK
    push(16'h5aa5);
    D = 16'h5aa5; WR = 1'b1;
    tick();
    WR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {STB, EN0, LD, Q}, {3'b110, 8'ha5});
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("t3_second", {STB, EN1, LD, Q}, {3'b111, 8'h5a});
    drain(2);
    exp_wcnt++;

    // back-to-back through the pending slot
    push(16'h1111); push(16'h2222);
    D = 16'h1111; WR = 1'b1;
    tick();
    D = 16'h2222;
    tick();
    WR = 1'b0;
    check("t4_busy", {31'd0, BUSY}, 1);
    n_done = 0;
    ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_no_gap", {31'd0, STB}, 1);
      tick();
    end
    tick();
    ACK = 1'b0;
    exp_wcnt += 2;
    check("t4_done2", n_done, 2);
    check("t4_wcnt", {24'd0, WCNT}, exp_wcnt);
    check("t4_hf_wrap", {30'd0, h_wcnt}, exp_wcnt % 4);

    // write coinciding with the final ACK, pending empty
    push(16'h1357); push(16'h2468);
    D = 16'h1357; WR = 1'b1; ACK = 1'b1;
    tick();
    WR = 1'b0;
    tick();
    D = 16'h2468; WR = 1'b1;
    tick();
    WR = 1'b0;
    check("t4b_direct", {BUSY, STB, EN0, Q}, {3'b011, 8'h68});
    drain(3);
    exp_wcnt += 2;
    check("t4b_wcnt", {24'd0, WCNT}, exp_wcnt);

    // overflow and clear
    push(16'hbeef); push(16'hcafe);
    D = 16'hbeef; WR = 1'b1;
    tick();
    D = 16'hcafe;
    tick();
    check("t5_busy", {31'd0, BUSY}, 1);
    D = 16'hdead;
    tick();
    WR = 1'b0;
    check("t5_ovr", {31'd0, OVR}, 1);
    drain(6);
    exp_wcnt += 2;
    check("t5_drained", q_lf.size() + q_hf.size(), 0);
    check("t5_wcnt", {24'd0, WCNT}, exp_wcnt);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    exp_wcnt = 0;
    check("t5_clr", {OVR, BUSY, STB}, 3'b000);
    check("t5_clr_wcnt", {24'd0, WCNT}, exp_wcnt);

    // CLR wins over final ACK
    push(16'h0f0f);
    D = 16'h0f0f; WR = 1'b1; ACK = 1'b1;
    tick();
    WR = 1'b0;
    tick();
    check("t6_in_second", {31'd0, LD}, 1);
    n_done = 0;
    CLR = 1'b1;
    flush();
    tick();
    CLR = 1'b0; ACK = 1'b0;
    check("t6_clr", {STB, EN0, EN1, LD, DONE}, 5'b0);
    tick();
    check("t6_no_done", n_done, 0);
    check("t6_wcnt", {24'd0, WCNT}, exp_wcnt);

    // async reset mid-word
    push(16'h7788);
    D = 16'h7788; WR = 1'b1;
    tick();
    WR = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("t7_async_rst", {STB, EN0, LD, BUSY, Q}, 12'h000);
    flush();
    tick();
    RESET = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
